// File: rtl/pavana_xbar_pkg.sv
// Shared types for the xbar slave endpoint: command encodings, tid type, pending-read entry, LFSR taps.
// Pure definitions; no timing or flow-control behaviour lives here.
package pavana_xbar_pkg;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    localparam int TID_W_DEF = 2;
    typedef logic [TID_W_DEF-1:0] tid_t;

    typedef struct packed {
        logic        busy;
        logic [7:0]  cnt;
        logic [31:0] data;
    } pend_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN
    } init_st_e;

    // Taps for x^8+x^6+x^5+x^4+1 in a shift-left Fibonacci register (bits 7,5,4,3).
    localparam logic [7:0] LFSR_TAP = 8'hB8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAP)};
    endfunction

endpackage

// File: rtl/slave_lat_lfsr.sv
// 8-bit Fibonacci LFSR producing a per-read latency; lat_o is combinational from the current state.
// State advances one step only when adv_i is high; no backpressure.
module slave_lat_lfsr
    import pavana_xbar_pkg::*;
#(
    parameter logic [7:0] SEED     = 8'hA5,
    parameter int         LAT_MIN  = 1,
    parameter logic [7:0] LAT_MASK = 8'd7
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       adv_i,
    output logic [7:0] lat_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (adv_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lat_o = 8'(LAT_MIN) + (lfsr_q & LAT_MASK);

endmodule

// File: rtl/slave_ooo_responder.sv
// Out-of-order tagged slave: word memory, one pending read per tid, lowest-tid-first response arbiter.
// Read resp lat+1 cycles after accept; ack withheld while the tid is busy. SLAVE_MEMINIT_EN adds a post-reset init sweep.
module slave_ooo_responder
    import pavana_xbar_pkg::*;
#(
    parameter int         MEMSIZE32 = 1024,
    parameter int         TID_W     = 2,
    parameter int         LAT_MIN   = 1,
    parameter int         LAT_MASK  = 7,
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter logic [1:0] SLAVE_ID  = 2'd0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             slave_req,
    input  logic [31:0]      slave_addr,
    input  logic             slave_cmd,
    input  logic [TID_W-1:0] slave_reqtid,
    input  logic [31:0]      slave_wdata,
    output logic             slave_ack,
    output logic [TID_W-1:0] slave_resptid,
    output logic [31:0]      slave_rdata,
    output logic             slave_resp
);

    localparam int NUM_TIDS = 2 ** TID_W;
    localparam int AW       = $clog2(MEMSIZE32);

    logic [31:0] mem [MEMSIZE32];

    pend_entry_t pend_q [NUM_TIDS];
    pend_entry_t pend_d [NUM_TIDS];

    logic             resp_vld_q, resp_vld_d;
    logic [TID_W-1:0] resp_tid_q, resp_tid_d;
    logic [31:0]      resp_dat_q, resp_dat_d;

    logic             init_done;
    logic             init_we;
    logic [AW-1:0]    init_idx;
    logic [31:0]      init_wdat;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [31:0]      mem_wdat;

    logic [AW-1:0]    word_idx;
    logic             rd_acc;
    logic             wr_acc;
    logic [7:0]       lat;
    logic             win_vld;
    logic [TID_W-1:0] win_tid;
    logic             unused_addr;

    // Upper address bits fold away so the index wraps modulo MEMSIZE32.
    assign word_idx    = slave_addr[AW+1:2];
    assign unused_addr = ^{slave_addr[31:AW+2], slave_addr[1:0]};

    assign slave_ack = slave_req & ~pend_q[slave_reqtid].busy & init_done;
    assign rd_acc    = slave_ack & (slave_cmd == CMD_RD);
    assign wr_acc    = slave_ack & (slave_cmd == CMD_WR);

    slave_lat_lfsr #(
        .SEED     (LFSR_SEED),
        .LAT_MIN  (LAT_MIN),
        .LAT_MASK (8'(LAT_MASK))
    ) u_lat (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .adv_i (rd_acc),
        .lat_o (lat)
    );

`ifdef SLAVE_MEMINIT_EN
    init_st_e      st_q, st_d;
    logic [AW-1:0] init_idx_q, init_idx_d;

    always_comb begin
        st_d       = st_q;
        init_idx_d = init_idx_q;
        case (st_q)
            ST_IDLE: begin
                st_d       = ST_INIT;
                init_idx_d = '0;
            end
            ST_INIT: begin
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == AW'(MEMSIZE32 - 1)) begin
                    st_d = ST_RUN;
                end
            end
            ST_RUN:  st_d = ST_RUN;
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            st_q       <= ST_IDLE;
            init_idx_q <= '0;
        end else begin
            st_q       <= st_d;
            init_idx_q <= init_idx_d;
        end
    end

    assign init_done = (st_q == ST_RUN);
    assign init_we   = (st_q == ST_INIT);
    assign init_idx  = init_idx_q;
    assign init_wdat = {SLAVE_ID, 30'd0} + (32'(init_idx_q) << 2);
`else
    assign init_done = 1'b1;
    assign init_we   = 1'b0;
    assign init_idx  = '0;
    assign init_wdat = '0;
`endif

    // A write arriving while reset is sampled must not disturb preserved memory.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = word_idx;
        mem_wdat  = slave_wdata;
        if (init_we) begin
            mem_we    = rst_i;
            mem_waddr = init_idx;
            mem_wdat  = init_wdat;
        end else if (wr_acc) begin
            mem_we = rst_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdat;
        end
    end

    always_comb begin
        win_vld = 1'b0;
        win_tid = '0;
        for (int i = 0; i < NUM_TIDS; i++) begin
            if (!win_vld && pend_q[i].busy && (pend_q[i].cnt == 8'd0)) begin
                win_vld = 1'b1;
                win_tid = TID_W'(i);
            end
        end

        for (int i = 0; i < NUM_TIDS; i++) begin
            pend_d[i] = pend_q[i];
            if (pend_q[i].cnt != 8'd0) begin
                pend_d[i].cnt = pend_q[i].cnt - 8'd1;
            end
            if (win_vld && (win_tid == TID_W'(i))) begin
                pend_d[i].busy = 1'b0;
            end
            // Read data is captured now, so later writes to the address cannot leak in.
            if (rd_acc && (slave_reqtid == TID_W'(i))) begin
                pend_d[i].busy = 1'b1;
                pend_d[i].cnt  = lat;
                pend_d[i].data = mem[word_idx];
            end
        end

        resp_vld_d = win_vld;
        resp_tid_d = resp_tid_q;
        resp_dat_d = resp_dat_q;
        if (win_vld) begin
            resp_tid_d = win_tid;
            resp_dat_d = pend_q[win_tid].data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NUM_TIDS; i++) begin
                pend_q[i] <= '0;
            end
            resp_vld_q <= 1'b0;
            resp_tid_q <= '0;
            resp_dat_q <= '0;
        end else begin
            pend_q     <= pend_d;
            resp_vld_q <= resp_vld_d;
            resp_tid_q <= resp_tid_d;
            resp_dat_q <= resp_dat_d;
        end
    end

    assign slave_resp    = resp_vld_q;
    assign slave_resptid = resp_tid_q;
    assign slave_rdata   = resp_dat_q;

endmodule

// File: tb/tb_slave_ooo_responder.sv
// Scoreboard bench: two DUTs (fixed latency and LFSR latency) fed by one request task; a negedge monitor matches responses by tid.
module tb_slave_ooo_responder;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        sel;
    logic [31:0] addr;
    logic        cmd;
    logic [1:0]  tid;
    logic [31:0] wdata;

    logic        ack_m, resp_m, ack_r, resp_r;
    logic [1:0]  rtid_m, rtid_r;
    logic [31:0] rdata_m, rdata_r;

    int cyc    = 0;
    int tests  = 0;
    int fails  = 0;

    typedef struct {
        bit          sel;
        logic [1:0]  tid;
        logic [31:0] dat;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    slave_ooo_responder #(.LAT_MIN(1), .LAT_MASK(0)) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .slave_req     (req & ~sel),
        .slave_addr    (addr),
        .slave_cmd     (cmd),
        .slave_reqtid  (tid),
        .slave_wdata   (wdata),
        .slave_ack     (ack_m),
        .slave_resptid (rtid_m),
        .slave_rdata   (rdata_m),
        .slave_resp    (resp_m)
    );

    slave_ooo_responder dut_r (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .slave_req     (req & sel),
        .slave_addr    (addr),
        .slave_cmd     (cmd),
        .slave_reqtid  (tid),
        .slave_wdata   (wdata),
        .slave_ack     (ack_r),
        .slave_resptid (rtid_r),
        .slave_rdata   (rdata_r),
        .slave_resp    (resp_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic check_resp(input bit s, input logic [1:0] t, input logic [31:0] d);
        int idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
            if (idx < 0 && sb[i].sel == s && sb[i].tid == t) idx = i;
        end
        tests++;
        if (idx < 0) begin
            fails++;
            $display("FAIL unexpected_resp: dut %0d tid %0d data %h at cycle %0d, required no response", s, t, d, cyc);
        end else begin
            chk($sformatf("rsp_data dut%0d tid%0d", s, t), d, sb[idx].dat);
            chk($sformatf("rsp_cycle dut%0d tid%0d", s, t), cyc, sb[idx].cyc);
            sb.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        if (resp_m) check_resp(1'b0, rtid_m, rdata_m);
        if (resp_r) check_resp(1'b1, rtid_r, rdata_r);
    end

    // Drives one request, holds it until accepted; a read with push=1 schedules its response dly cycles after accept.
    task automatic do_req(input bit s, input logic c, input logic [31:0] a, input logic [1:0] t,
                          input logic [31:0] wd, input logic [31:0] exp_d, input int dly, input bit push,
                          output int acc, output int waited);
        exp_t e;
        waited = 0;
        acc    = -1;
        @(negedge clk);
        sel = s; cmd = c; addr = a; tid = t; wdata = wd; req = 1'b1;
        forever begin
            #1;
            if (s ? ack_r : ack_m) break;
            if (waited >= 200) begin
                tests++;
                fails++;
                $display("FAIL ack_timeout: tid %0d not accepted after %0d cycles, required acceptance", t, waited);
                req = 1'b0;
                return;
            end
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        req = 1'b0;
        if (c == RD && push) begin
            e.sel = s; e.tid = t; e.dat = exp_d; e.cyc = acc + dly;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        repeat (14) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, w;
        req = 0; sel = 0; addr = 0; cmd = 0; tid = 0; wdata = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset resp_m", {31'd0, resp_m}, 32'd0);
        chk("reset rtid_m", {30'd0, rtid_m}, 32'd0);
        chk("reset rdata_m", rdata_m, 32'd0);
        chk("reset resp_r", {31'd0, resp_r}, 32'd0);
        chk("reset rdata_r", rdata_r, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle ack_m", {31'd0, ack_m}, 32'd0);

        // Write then read back, fixed latency 1 -> response 2 cycles after read accept.
        do_req(0, WR, 32'h10, 2'd0, 32'hDEADBEEF, 0, 0, 0, a1, w);
        chk("t1 wr wait", w, 0);
        do_req(0, RD, 32'h10, 2'd1, 0, 32'hDEADBEEF, 2, 1, a1, w);
        chk("t1 rd wait", w, 0);

        for (int i = 0; i < 4; i++) begin
            do_req(0, WR, 32'(i * 4), 2'(i), 32'hC0DE0000 + 32'(i), 0, 0, 0, a1, w);
            do_req(1, WR, 32'(i * 4), 2'(i), 32'hBEEF0000 + 32'(i), 0, 0, 0, a1, w);
        end
        drain();

        // Four back-to-back reads, fixed latency.
        for (int i = 0; i < 4; i++) begin
            do_req(0, RD, 32'(i * 4), 2'(i), 0, 32'hC0DE0000 + 32'(i), 2, 1, a1, w);
            chk("t2 rd wait", w, 0);
        end
        drain();

        // LFSR latencies from seed A5: 6,3,6,3. tid0 and tid3 collide; tid0 wins, tid3 one cycle later.
        do_req(1, RD, 32'h0, 2'd0, 0, 32'hBEEF0000, 7, 1, a1, w);
        do_req(1, RD, 32'h4, 2'd1, 0, 32'hBEEF0001, 4, 1, a1, w);
        do_req(1, RD, 32'h8, 2'd2, 0, 32'hBEEF0002, 7, 1, a1, w);
        do_req(1, RD, 32'hC, 2'd3, 0, 32'hBEEF0003, 5, 1, a1, w);
        drain();

        // Busy tid: held request accepted the cycle after the first response.
        do_req(0, RD, 32'h10, 2'd2, 0, 32'hDEADBEEF, 2, 1, a1, w);
        do_req(0, RD, 32'h4, 2'd2, 0, 32'hC0DE0001, 2, 1, a2, w);
        chk("t3 busy wait", w, 2);
        chk("t3 accept gap", a2 - a1, 3);
        drain();

        // Read data captured at accept, unaffected by a following write.
        do_req(0, WR, 32'h20, 2'd0, 32'h11111111, 0, 0, 0, a1, w);
        do_req(0, RD, 32'h20, 2'd3, 0, 32'h11111111, 2, 1, a1, w);
        do_req(0, WR, 32'h20, 2'd0, 32'h22222222, 0, 0, 0, a1, w);
        do_req(0, RD, 32'h20, 2'd1, 0, 32'h22222222, 2, 1, a1, w);
        drain();

        // Address wrap: 0x1000 maps to word 0.
        do_req(0, RD, 32'h1000, 2'd0, 0, 32'hC0DE0000, 2, 1, a1, w);
        drain();

        // Reset with two reads in flight: both dropped, outputs cleared.
        do_req(0, RD, 32'h4, 2'd0, 0, 0, 0, 0, a1, w);
        do_req(0, RD, 32'h8, 2'd1, 0, 0, 0, 0, a1, w);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid reset resp_m", {31'd0, resp_m}, 32'd0);
        chk("mid reset rtid_m", {30'd0, rtid_m}, 32'd0);
        chk("mid reset rdata_m", rdata_m, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        do_req(0, RD, 32'h10, 2'd0, 0, 32'hDEADBEEF, 2, 1, a1, w);
        chk("post reset ack wait", w, 0);
        drain();

        chk("scoreboard empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
